// File: rtl/icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm -- direct-mapped, one-word-per-frame instruction cache.
//
// Hits return data combinationally in the same cycle as the request. A miss
// latches the fetch address and then holds a memory read until the memory
// drops iwait. The returned word is written into the frame, and the cache
// goes back to IDLE. The datapath then sees a hit on its next fetch.
//
// Optional feature macro: ICACHE_HITCNT_EN
//   When this macro is defined, the block adds the hit_count and miss_count
//   output ports and the counters that drive them.
// ---------------------------------------------------------------------------
module icache_dm #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_HITCNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t             state_r;
    state_t             next_state_s;

    logic [SETS-1:0]    valid_r;
    logic [TAG_W-1:0]   tag_r  [SETS];
    logic [31:0]        data_r [SETS];
    logic [31:0]        miss_addr_r;

    logic [IDX_W-1:0]   idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [IDX_W-1:0]   miss_idx_s;
    logic [TAG_W-1:0]   miss_tag_s;
    logic               hit_s;
    logic               latch_miss_s;
    logic               fill_s;

    // Split the fetch address and the held miss address into index and tag fields.
    always_comb begin
        idx_s      = imemaddr[IDX_W+1:2];
        tag_s      = imemaddr[31:IDX_W+2];
        miss_idx_s = miss_addr_r[IDX_W+1:2];
        miss_tag_s = miss_addr_r[31:IDX_W+2];
    end

    // Compute the next state and the hit, miss-latch and fill strobes.
    always_comb begin
        next_state_s = state_r;
        hit_s        = 1'b0;
        latch_miss_s = 1'b0;
        fill_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (imemREN && valid_r[idx_s] && (tag_r[idx_s] == tag_s)) begin
                    hit_s        = 1'b1;
                    next_state_s = IDLE;
                end else if (imemREN) begin
                    latch_miss_s = 1'b1;
                    next_state_s = MISS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            MISS: begin
                if (!iwait) begin
                    fill_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = MISS;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Drive the datapath and memory-side outputs; iaddr is zero unless a read is active.
    always_comb begin
        ihit     = hit_s;
        imemload = data_r[idx_s];
        iREN     = (state_r == MISS);
        if (state_r == MISS) begin
            iaddr = miss_addr_r;
        end else begin
            iaddr = 32'h0000_0000;
        end
    end

    // State register. A reset during MISS drops the fill immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the missing fetch address. It stays fixed while the fill is outstanding.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_addr_r <= 32'h0000_0000;
        end else if (latch_miss_s) begin
            miss_addr_r <= imemaddr;
        end else begin
            miss_addr_r <= miss_addr_r;
        end
    end

    // Valid bits. Reset clears them all, and a completed fill sets the filled frame.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_r <= {SETS{1'b0}};
        end else if (fill_s) begin
            valid_r[miss_idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data arrays. A fill overwrites the frame; there is no reset because the valid bit qualifies the contents.
    always_ff @(posedge CLK) begin
        if (fill_s) begin
            tag_r[miss_idx_s]  <= miss_tag_s;
            data_r[miss_idx_s] <= iload;
        end
    end

`ifdef ICACHE_HITCNT_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Performance counters: count IDLE hits and IDLE-to-MISS transitions. Both wrap naturally.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_r  <= 32'h0000_0000;
            miss_count_r <= 32'h0000_0000;
        end else begin
            if (hit_s) begin
                hit_count_r <= hit_count_r + 32'h0000_0001;
            end else begin
                hit_count_r <= hit_count_r;
            end
            if (latch_miss_s) begin
                miss_count_r <= miss_count_r + 32'h0000_0001;
            end else begin
                miss_count_r <= miss_count_r;
            end
        end
    end

    // Expose the counter registers on the output ports.
    always_comb begin
        hit_count  = hit_count_r;
        miss_count = miss_count_r;
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// ---------------------------------------------------------------------------
// tb_icache_dm -- directed, table-driven bench for icache_dm (SETS=16).
// Inputs change 1 ns after a rising edge. Outputs are checked on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_icache_dm;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_HITCNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    icache_dm #(.SETS(16)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_HITCNT_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        iw;
        logic [31:0] ld;
        logic        e_hit;
        logic        e_iren;
        logic [31:0] e_iaddr;
        logic        chk_load;
        logic [31:0] e_load;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ren, input logic [31:0] addr, input logic iw,
                       input logic [31:0] ld, input logic e_hit, input logic e_iren,
                       input logic [31:0] e_iaddr, input logic chk_load,
                       input logic [31:0] e_load);
        vec_t v;
        v.ren = ren; v.addr = addr; v.iw = iw; v.ld = ld;
        v.e_hit = e_hit; v.e_iren = e_iren; v.e_iaddr = e_iaddr;
        v.chk_load = chk_load; v.e_load = e_load;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Cold miss on 0x40, with the memory busy for two cycles.
        add(1'b1, 32'h40, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        add(1'b1, 32'h40, 1'b1, 32'h0,        1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        add(1'b1, 32'h40, 1'b1, 32'h0,        1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        add(1'b1, 32'h40, 1'b0, 32'h8C220004, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        add(1'b1, 32'h40, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'h8C220004);
        // Repeat hit on 0x40.
        add(1'b1, 32'h40, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'h8C220004);
        // Conflict: 0x80 maps to index 0 with a different tag.
        add(1'b1, 32'h80, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        add(1'b1, 32'h80, 1'b0, 32'h11111111, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        add(1'b1, 32'h80, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'h11111111);
        add(1'b1, 32'h40, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        add(1'b1, 32'h40, 1'b0, 32'h22222222, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        add(1'b1, 32'h40, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'h22222222);
        // Address moves from 0x44 to 0x48 while the miss is outstanding.
        add(1'b1, 32'h44, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        add(1'b1, 32'h48, 1'b1, 32'h0,        1'b0, 1'b1, 32'h44, 1'b0, 32'h0);
        add(1'b1, 32'h48, 1'b0, 32'h33333333, 1'b0, 1'b1, 32'h44, 1'b0, 32'h0);
        add(1'b1, 32'h48, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        add(1'b1, 32'h48, 1'b0, 32'h44444444, 1'b0, 1'b1, 32'h48, 1'b0, 32'h0);
        add(1'b1, 32'h44, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'h33333333);
        add(1'b1, 32'h48, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'h44444444);
        // No request: the cache stays IDLE with no memory traffic.
        add(1'b0, 32'h40, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        add(1'b0, 32'h40, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        add(1'b1, 32'h40, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'h22222222);
        // imemREN drops during MISS, and the fill still completes.
        add(1'b1, 32'hC0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        add(1'b0, 32'hC0, 1'b0, 32'h55555555, 1'b0, 1'b1, 32'hC0, 1'b0, 32'h0);
        add(1'b1, 32'hC0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,  1'b1, 32'h55555555);

        // Reset state.
        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0;
        #2;
        check("rst ihit", {31'h0, ihit}, 32'h0);
        check("rst iREN", {31'h0, iREN}, 32'h0);
        check("rst iaddr", iaddr, 32'h0);
`ifdef ICACHE_HITCNT_EN
        check("rst hit_count", hit_count, 32'h0);
        check("rst miss_count", miss_count, 32'h0);
`endif
        imemREN = 1'b0;
        #10 nRST = 1'b1;
        @(posedge CLK); #1;

        // Table.
        for (int i = 0; i < vq.size(); i++) begin
            imemREN  = vq[i].ren;
            imemaddr = vq[i].addr;
            iwait    = vq[i].iw;
            iload    = vq[i].ld;
            @(negedge CLK);
            check($sformatf("v%0d ihit", i), {31'h0, ihit}, {31'h0, vq[i].e_hit});
            check($sformatf("v%0d iREN", i), {31'h0, iREN}, {31'h0, vq[i].e_iren});
            check($sformatf("v%0d iaddr", i), iaddr, vq[i].e_iaddr);
            if (vq[i].chk_load) begin
                check($sformatf("v%0d imemload", i), imemload, vq[i].e_load);
            end
            @(posedge CLK); #1;
        end

`ifdef ICACHE_HITCNT_EN
        // The table contains 8 hits and 6 misses.
        check("hit_count table", hit_count, 32'd8);
        check("miss_count table", miss_count, 32'd6);
        // Wrap the hit counter from FFFFFFFF to 0.
        force dut.hit_count_r = 32'hFFFF_FFFF;
        #1 release dut.hit_count_r;
        imemREN = 1'b1; imemaddr = 32'hC0; iwait = 1'b1;
        @(negedge CLK);
        check("wrap ihit", {31'h0, ihit}, 32'h1);
        @(posedge CLK); #1;
        check("hit_count wrap", hit_count, 32'h0);
        check("miss_count no change", miss_count, 32'd6);
`endif

        // Reset during MISS: the fill is abandoned.
        imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
        @(negedge CLK);
        check("rm miss ihit", {31'h0, ihit}, 32'h0);
        @(posedge CLK); #1;
        check("rm MISS iREN", {31'h0, iREN}, 32'h1);
        check("rm MISS iaddr", iaddr, 32'h100);
        #1 nRST = 1'b0;
        #1;
        check("rm async iREN", {31'h0, iREN}, 32'h0);
        check("rm async iaddr", iaddr, 32'h0);
        check("rm async ihit", {31'h0, ihit}, 32'h0);
        iwait = 1'b0; iload = 32'h66666666;
        @(posedge CLK); #1;
        nRST = 1'b1; iwait = 1'b1;
        @(negedge CLK);
        check("rm refetch ihit", {31'h0, ihit}, 32'h0);
`ifdef ICACHE_HITCNT_EN
        check("rm miss_count cleared", miss_count, 32'h0);
`endif
        imemaddr = 32'h40;
        #1;
        check("rm valid cleared ihit", {31'h0, ihit}, 32'h0);
        imemREN = 1'b0;
        @(posedge CLK); #1;
        check("rm idle iREN", {31'h0, iREN}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
